sha256_w_schedule: RTL and testbench
====================================

# sha256_w_schedule

Message-schedule producer for the SHA-256 datapath. It loads one 512-bit message block as 16 big-endian 32-bit words and generates the 64 schedule words W[0..63]. Each W[t] is emitted with its round constant K[t] over a valid/ready handshake. It is the upstream end of the round-stage interface and supplies the `w`/`k` operands that each compression round (F stage) consumes, one round per accepted transfer.

## Interface
Parameters:
- `DATA_W`, 32: word width. Only 32 is supported; any other value is a synthesis-time error.

Ports:
- `clk`: input, 1 bit. Single clock; all state updates on the rising edge.
- `rst`: input, 1 bit. Reset, asynchronous and active-low.
- `run`: input, 1 bit. Start pulse. Sampled only in IDLE.
- `in_valid`: input, 1 bit. Message word valid.
- `in_ready`: output, 1 bit. Message word accepted when `in_valid && in_ready`.
- `in_data`: input, DATA_W bits. Message word. W0 arrives first.
- `w_valid`: output, 1 bit. Schedule word available.
- `w_ready`: input, 1 bit. Round stage consumes the word when `w_valid && w_ready` (a "fire").
- `w_out`: output, DATA_W bits. W[round].
- `k_out`: output, DATA_W bits. K[round].
- `round`: output, 6 bits. Index of the word currently presented.
- `last`: output, 1 bit. `w_valid && round==63`.
- `busy`: output, 1 bit. High whenever state is not IDLE.
- `done`: output, 1 bit. One-cycle pulse after the final fire.

## Operation
- State machine has three states: IDLE, LOAD and GEN.
- IDLE:
  - `in_ready=0` and `w_valid=0`.
  - `run=1` moves the block to LOAD on the next edge; the load counter is cleared.
- LOAD:
  - `in_ready=1`.
  - Each accepted word is written into window slot [cnt], then cnt is incremented.
  - The fire that carries cnt==15 moves the block to GEN with round=0.
  - `w_ready` is ignored in this state.
- GEN:
  - `w_valid=1`.
  - `w_out` is window[0]; `k_out` is K[round], read from the package constant table.
  - On each fire, the window shifts down one slot and a new word enters slot 15. The new word is σ1(window[14]) + window[9] + σ0(window[1]) + window[0], i.e. W[t+16] computed in the same cycle.
  - round increments on each fire.
  - The fire at round==63 returns the block to IDLE and asserts `done` on the next cycle.
- σ0(x) = ROTR7 ^ ROTR18 ^ SHR3. σ1(x) = ROTR17 ^ ROTR19 ^ SHR10.
- All additions are modulo 2^32; carries are discarded.
- Words computed after round 47 are never emitted. Computing them is allowed and harmless.
- `run` in LOAD or GEN is ignored and does not restart the block.
- `in_valid` outside LOAD is ignored.
- Reset (asynchronous, `rst`=0) clears every register:
  - state=IDLE, cnt=0, round=0, window all zero.
  - `w_out`=0, `k_out`=K[0]=0x428a2f98 (combinational from round=0).
  - `in_ready`=0, `w_valid`=0, `last`=0, `busy`=0, `done`=0.
- Reset asserted mid-LOAD or mid-GEN abandons the block with no `done` pulse.

## Timing
- `run` at edge N puts the block in LOAD: `in_ready=1` from cycle N+1.
- The 16th accepted word at edge M puts the block in GEN: `w_valid=1`, round=0, `w_out`=W0 in cycle M+1.
- There is no bubble between rounds: back-to-back fires emit one word per cycle, so 64 words take 64 cycles at `w_ready=1`.
- Backpressure: while `w_valid && !w_ready`, `w_out`, `k_out`, `round` and `last` hold stable.
- The final fire at edge P gives state=IDLE and `done=1` in cycle P+1 only, with `busy=0` in that same cycle.
- `run` may be asserted in the `done` cycle and is accepted.
- Minimum block period is 1 (run) + 16 (load) + 64 (generate) = 81 cycles.

## Structure
- Shared package `sha256_pkg` holds:
  - The 64-entry K constant array.
  - `sigma0`/`sigma1` functions, shared with the round stages.
  - State encoding localparams (IDLE/LOAD/GEN).
  - Constants `SHA_ROUNDS=64` and `SHA_BLK_WORDS=16`.
- No sub-module. The 16×32 shift window, counters and FSM fit in a single module.

## Test plan
- "abc" padded block: W0=0x61626380, W1..W14=0, W15=0x00000018.
  - Required: W0..W15 echoed in order.
  - W16=0x61626380, W17=0x000f0000.
  - k_out=0x428a2f98 at round 0 and 0xc67178f2 at round 63.
  - `done` is exactly one cycle, one cycle after the round-63 fire.
- Random `w_ready` (50% duty), random message block:
  - Every `w_out` matches a software W[t] model.
  - Outputs hold stable across stalls.
  - Exactly 64 fires occur, with `last` only at round 63.
- Gapped `in_valid` during LOAD (idle cycles between words): the block enters GEN only after the 16th accepted word, and round 0 equals the first accepted word.
- `run` pulsed during LOAD and again at round 30: the run is ignored, round continues to 63, and no extra words are loaded.
- `rst` asserted at round 20 mid-stall:
  - Outputs immediately reach reset values: `w_valid`=0, `busy`=0, `k_out`=0x428a2f98.
  - No `done` pulse.
  - A subsequent "abc" block produces the correct schedule.
- Back-to-back blocks with `run` asserted in the `done` cycle: the second block starts with `in_ready=1` on the next cycle, and both schedules are correct.

Source files
------------

// File: rtl/sha256_pkg.sv
`default_nettype none
//============================================================================
// Module  : sha256_pkg
// Purpose : Shared SHA-256 definitions: round constant table K[0..63],
//           message-schedule sigma functions, schedule FSM encoding and
//           block/round size constants.
// Revision: 1.0 - initial release
//============================================================================
package sha256_pkg;

    localparam int SHA_ROUNDS    = 64;
    localparam int SHA_BLK_WORDS = 16;

    // Schedule FSM encoding
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOAD = 2'd1;
    localparam logic [1:0] ST_GEN  = 2'd2;

    typedef enum logic [1:0] {
        IDLE = ST_IDLE,
        LOAD = ST_LOAD,
        GEN  = ST_GEN
    } sched_state_t;

    // First 32 bits of the fractional parts of the cube roots of the
    // first 64 primes.
    localparam logic [31:0] SHA_K [0:SHA_ROUNDS-1] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    // sigma0(x) = ROTR7 ^ ROTR18 ^ SHR3
    function automatic logic [31:0] sigma0(input logic [31:0] x);
        return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
    endfunction

    // sigma1(x) = ROTR17 ^ ROTR19 ^ SHR10
    function automatic logic [31:0] sigma1(input logic [31:0] x);
        return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
    endfunction

endpackage
`default_nettype wire

// File: rtl/sha256_w_schedule.sv
`default_nettype none
//============================================================================
// Module  : sha256_w_schedule
// Purpose : Loads a 512-bit block as 16 big-endian words and streams the
//           64 SHA-256 schedule words W[t] with round constant K[t].
// Ports   : clk, rst (async, active-low)
//           run                         - start pulse, sampled in IDLE
//           in_valid/in_ready/in_data   - message word input, W0 first
//           w_valid/w_ready/w_out/k_out - schedule word output stream
//           round                       - index of word presented
//           last                        - w_valid at round 63
//           busy                        - FSM not in IDLE
//           done                        - one-cycle pulse after final fire
// Revision: 1.0 - initial release
//============================================================================
module sha256_w_schedule
    import sha256_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              run,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              w_valid,
    input  logic              w_ready,
    output logic [DATA_W-1:0] w_out,
    output logic [DATA_W-1:0] k_out,
    output logic [5:0]        round,
    output logic              last,
    output logic              busy,
    output logic              done
);

    generate
        if (DATA_W != 32) begin : g_bad_data_w
            $error("sha256_w_schedule: DATA_W must be 32");
        end
    endgenerate

    localparam logic [5:0] LAST_ROUND = 6'(SHA_ROUNDS - 1);
    localparam logic [3:0] LAST_WORD  = 4'(SHA_BLK_WORDS - 1);

    sched_state_t      r_state;
    sched_state_t      w_state_nxt;
    logic [3:0]        r_cnt;
    logic [5:0]        r_round;
    logic [DATA_W-1:0] r_window [SHA_BLK_WORDS];
    logic              r_done;

    logic              w_load_fire;
    logic              w_gen_fire;
    logic [DATA_W-1:0] w_next_word;

    assign w_load_fire = (r_state == LOAD) && in_valid;
    assign w_gen_fire  = (r_state == GEN) && w_ready;

    // Window holds W[t..t+15] while round t is presented, so this is W[t+16].
    assign w_next_word = sigma1(r_window[14]) + r_window[9]
                       + sigma0(r_window[1]) + r_window[0];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        w_valid     = 1'b0;
        busy        = 1'b1;
        case (r_state)
            IDLE: begin
                busy = 1'b0;
                if (run) begin
                    w_state_nxt = LOAD;
                end
            end
            LOAD: begin
                in_ready = 1'b1;
                if (in_valid && (r_cnt == LAST_WORD)) begin
                    w_state_nxt = GEN;
                end
            end
            GEN: begin
                w_valid = 1'b1;
                if (w_ready && (r_round == LAST_ROUND)) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt   <= '0;
            r_round <= '0;
            r_done  <= 1'b0;
            for (int i = 0; i < SHA_BLK_WORDS; i++) begin
                r_window[i] <= '0;
            end
        end else begin
            r_done <= w_gen_fire && (r_round == LAST_ROUND);

            if ((r_state == IDLE) && run) begin
                r_cnt <= '0;
            end

            if (w_load_fire) begin
                r_window[r_cnt] <= in_data;
                r_cnt           <= r_cnt + 4'd1;
                if (r_cnt == LAST_WORD) begin
                    r_round <= '0;
                end
            end

            // Round counter wraps 63 -> 0, so IDLE presents K[0] again.
            if (w_gen_fire) begin
                for (int i = 0; i < SHA_BLK_WORDS - 1; i++) begin
                    r_window[i] <= r_window[i+1];
                end
                r_window[SHA_BLK_WORDS-1] <= w_next_word;
                r_round                   <= r_round + 6'd1;
            end
        end
    end

    assign w_out = r_window[0];
    assign k_out = SHA_K[r_round];
    assign round = r_round;
    assign last  = w_valid && (r_round == LAST_ROUND);
    assign done  = r_done;

endmodule
`default_nettype wire

// File: tb/tb_sha256_w_schedule.sv
`default_nettype none
//============================================================================
// Module  : tb_sha256_w_schedule
// Purpose : Self-checking bench for sha256_w_schedule against a recurrence
//           model of the SHA-256 message schedule.
// Revision: 1.0 - initial release
//============================================================================
module tb_sha256_w_schedule;

    logic        clk = 1'b0;
    logic        rst;
    logic        run;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        w_valid;
    logic        w_ready;
    logic [31:0] w_out;
    logic [31:0] k_out;
    logic [5:0]  round;
    logic        last;
    logic        busy;
    logic        done;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] msg   [16];
    logic [31:0] exp_w [64];
    logic [31:0] obs_w [64];
    logic [31:0] obs_k [64];

    logic [31:0] KT [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    sha256_w_schedule #(.DATA_W(32)) dut (
        .clk      (clk),
        .rst      (rst),
        .run      (run),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .w_valid  (w_valid),
        .w_ready  (w_ready),
        .w_out    (w_out),
        .k_out    (k_out),
        .round    (round),
        .last     (last),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        logic [63:0] t;
        t = {x, x} >> n;
        return t[31:0];
    endfunction

    function automatic logic [31:0] m_s0(input logic [31:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] m_s1(input logic [31:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    task automatic build_model();
        for (int t = 0; t < 16; t++) exp_w[t] = msg[t];
        for (int t = 16; t < 64; t++)
            exp_w[t] = m_s1(exp_w[t-2]) + exp_w[t-7] + m_s0(exp_w[t-15]) + exp_w[t-16];
    endtask

    task automatic set_abc();
        for (int i = 0; i < 16; i++) msg[i] = 32'h0;
        msg[0]  = 32'h61626380;
        msg[15] = 32'h00000018;
        build_model();
    endtask

    task automatic set_random();
        for (int i = 0; i < 16; i++) msg[i] = $urandom;
        build_model();
    endtask

    // ---------------- stimulus tasks (called at a negedge) ----------------
    task automatic start_block();
        run = 1'b1;
        @(negedge clk);
        run = 1'b0;
        n_checks++;
        if ({in_ready, busy, w_valid} !== 3'b110)
            $display("FAIL start_load: got rdy/busy/wv=%b required 110", {in_ready, busy, w_valid});
    endtask

    task automatic load_block(input int gap_pct, input bit run_mid);
        int acc = 0;
        int cyc = 0;
        while (acc < 16 && cyc < 400) begin
            n_checks++;
            if ({in_ready, w_valid, busy} !== 3'b101) begin
                n_fail++;
                $display("FAIL load_state: word %0d got rdy/wv/busy=%b required 101", acc, {in_ready, w_valid, busy});
            end
            run = run_mid && (acc == 8);
            if ($urandom_range(99) < gap_pct) begin
                in_valid = 1'b0;
                in_data  = $urandom;
            end else begin
                in_valid = 1'b1;
                in_data  = msg[acc];
            end
            if (in_valid) acc++;
            @(negedge clk);
            cyc++;
        end
        in_valid = 1'b0;
        run      = 1'b0;
        n_checks++;
        if (acc != 16) begin
            n_fail++;
            $display("FAIL load_timeout: got %0d words required 16", acc);
        end
    endtask

    task automatic collect(input int ready_pct, input int run_round, input int stop_at,
                           input bit run_on_done);
        int          idx = 0;
        int          cyc = 0;
        bit          stalled = 1'b0;
        logic [31:0] pw, pk;
        logic [5:0]  pr;
        logic        pl;
        pw = '0; pk = '0; pr = '0; pl = 1'b0;
        while (idx < 64 && cyc < 2000) begin
            n_checks++;
            if ({w_valid, busy, done, in_ready} !== 4'b1100) begin
                n_fail++;
                $display("FAIL gen_ctrl: round %0d got wv/busy/done/rdy=%b required 1100", idx, {w_valid, busy, done, in_ready});
            end
            n_checks++;
            if (round !== 6'(idx)) begin
                n_fail++;
                $display("FAIL round_idx: got %0d required %0d", round, idx);
            end
            n_checks++;
            if (w_out !== exp_w[idx]) begin
                n_fail++;
                $display("FAIL w_out: round %0d got %h required %h", idx, w_out, exp_w[idx]);
            end
            n_checks++;
            if (k_out !== KT[idx]) begin
                n_fail++;
                $display("FAIL k_out: round %0d got %h required %h", idx, k_out, KT[idx]);
            end
            n_checks++;
            if (last !== (idx == 63)) begin
                n_fail++;
                $display("FAIL last: round %0d got %b required %b", idx, last, (idx == 63));
            end
            if (stalled) begin
                n_checks++;
                if ({w_out, k_out, round, last} !== {pw, pk, pr, pl}) begin
                    n_fail++;
                    $display("FAIL stall_hold: round %0d got %h/%h/%0d/%b required %h/%h/%0d/%b",
                             idx, w_out, k_out, round, last, pw, pk, pr, pl);
                end
            end
            if (idx == stop_at) return;
            obs_w[idx] = w_out;
            obs_k[idx] = k_out;
            pw = w_out; pk = k_out; pr = round; pl = last;
            w_ready  = ($urandom_range(99) < ready_pct);
            run      = (idx == run_round);
            in_valid = $urandom_range(1);
            in_data  = $urandom;
            stalled  = !w_ready;
            if (w_ready) idx++;
            @(negedge clk);
            cyc++;
        end
        w_ready  = 1'b0;
        run      = 1'b0;
        in_valid = 1'b0;
        n_checks++;
        if (idx != 64) begin
            n_fail++;
            $display("FAIL gen_timeout: got %0d fires required 64", idx);
        end
        n_checks++;
        if ({done, busy, w_valid, in_ready} !== 4'b1000) begin
            n_fail++;
            $display("FAIL done_pulse: got done/busy/wv/rdy=%b required 1000", {done, busy, w_valid, in_ready});
        end
        if (run_on_done) run = 1'b1;
        @(negedge clk);
        run = 1'b0;
        n_checks++;
        if (done !== 1'b0) begin
            n_fail++;
            $display("FAIL done_width: got done=%b required 0", done);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b0;
        #12;
        n_checks++;
        if ({in_ready, w_valid, last, busy, done, w_out, k_out, round} !==
            {5'b00000, 32'h0, 32'h428a2f98, 6'd0}) begin
            n_fail++;
            $display("FAIL reset_vals: got ctl=%b w=%h k=%h r=%0d required ctl=00000 w=0 k=428a2f98 r=0",
                     {in_ready, w_valid, last, busy, done}, w_out, k_out, round);
        end
        @(negedge clk);
        rst = 1'b1;
        in_valid = 1'b1;
        in_data  = 32'hdeadbeef;
        @(negedge clk);
        in_valid = 1'b0;
        n_checks++;
        if ({in_ready, w_valid, busy, done, w_out} !== {4'b0000, 32'h0}) begin
            n_fail++;
            $display("FAIL idle_hold: got ctl=%b w=%h required ctl=0000 w=0",
                     {in_ready, w_valid, busy, done}, w_out);
        end
    endtask

    task automatic test_abc();
        set_abc();
        start_block();
        load_block(0, 1'b0);
        collect(100, -1, 64, 1'b0);
        n_checks++;
        if (obs_w[16] !== 32'h61626380) begin
            n_fail++;
            $display("FAIL abc_w16: got %h required 61626380", obs_w[16]);
        end
        n_checks++;
        if (obs_w[17] !== 32'h000f0000) begin
            n_fail++;
            $display("FAIL abc_w17: got %h required 000f0000", obs_w[17]);
        end
        n_checks++;
        if (obs_w[15] !== 32'h00000018 || obs_w[0] !== 32'h61626380) begin
            n_fail++;
            $display("FAIL abc_echo: got w0=%h w15=%h required 61626380/00000018", obs_w[0], obs_w[15]);
        end
        n_checks++;
        if (obs_k[0] !== 32'h428a2f98 || obs_k[63] !== 32'hc67178f2) begin
            n_fail++;
            $display("FAIL abc_k: got k0=%h k63=%h required 428a2f98/c67178f2", obs_k[0], obs_k[63]);
        end
    endtask

    task automatic test_random_ready();
        set_random();
        start_block();
        load_block(0, 1'b0);
        collect(50, -1, 64, 1'b0);
    endtask

    task automatic test_gapped_load();
        set_random();
        start_block();
        load_block(50, 1'b0);
        collect(100, -1, 64, 1'b0);
    endtask

    task automatic test_run_ignored();
        set_random();
        start_block();
        load_block(20, 1'b1);
        collect(70, 30, 64, 1'b0);
    endtask

    task automatic test_reset_mid();
        set_random();
        start_block();
        load_block(0, 1'b0);
        collect(100, -1, 20, 1'b0);
        w_ready = 1'b0;
        @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        n_checks++;
        if ({w_valid, busy, in_ready, done, last, k_out, w_out, round} !==
            {5'b00000, 32'h428a2f98, 32'h0, 6'd0}) begin
            n_fail++;
            $display("FAIL midreset_vals: got ctl=%b k=%h w=%h r=%0d required ctl=00000 k=428a2f98 w=0 r=0",
                     {w_valid, busy, in_ready, done, last}, k_out, w_out, round);
        end
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_checks++;
            if ({done, busy} !== 2'b00) begin
                n_fail++;
                $display("FAIL midreset_nodone: cycle %0d got done/busy=%b required 00", i, {done, busy});
            end
        end
        test_abc();
    endtask

    task automatic test_back_to_back();
        set_random();
        start_block();
        load_block(0, 1'b0);
        collect(100, -1, 64, 1'b1);
        n_checks++;
        if ({in_ready, busy} !== 2'b11) begin
            n_fail++;
            $display("FAIL b2b_start: got rdy/busy=%b required 11", {in_ready, busy});
        end
        set_random();
        load_block(0, 1'b0);
        collect(75, -1, 64, 1'b0);
    endtask

    initial begin
        rst      = 1'b0;
        run      = 1'b0;
        in_valid = 1'b0;
        in_data  = 32'h0;
        w_ready  = 1'b0;
        test_reset();
        test_abc();
        test_random_ready();
        test_gapped_load();
        test_run_ignored();
        test_reset_mid();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
